mul_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-cycle multiplier (`mul_wrapper`/`mul` val/rdy interface) among `p_nreqs` requesters. It records the owner of every in-flight multiply in an in-order tag FIFO and steers each multiplier response back to its owner. It sits between the requesting PEs and the multiplier request/response ports, in the multiplier's clock domain.

---
 rtl/mul_arb_pkg.sv | 16 +
 rtl/mul_arb_tag_fifo.sv | 56 +++++
 rtl/mul_arbiter.sv | 102 ++++++++++
 tb/tb_mul_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared helpers for the multiplier arbiter: tag width and message width derivation.
package mul_arb_pkg;

  // Tag must be at least one bit even for a single requester.
  function automatic int unsigned tag_width(input int unsigned nreqs);
    return (nreqs > 1) ? $clog2(nreqs) : 1;
  endfunction

  function automatic int unsigned msg_bits(input int unsigned width);
    return 2 * width;
  endfunction

  // Message type for the default operand width; modules derive their own via msg_bits().
  typedef logic [7:0] msg_default_t;

endpackage

// File: rtl/mul_arb_tag_fifo.sv
// In-order FIFO of owner tags for in-flight multiplies; async active-high reset.
module mul_arb_tag_fifo #(
  parameter int unsigned p_width = 1,
  parameter int unsigned p_depth = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [p_width-1:0]           push_data,
  input  logic                         pop,
  output logic [p_width-1:0]           pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(p_depth+1)-1:0] count
);

  localparam int unsigned ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned cnt_w = $clog2(p_depth + 1);

  logic [p_width-1:0] mem [p_depth];
  logic [ptr_w-1:0]   head_q, tail_q;
  logic [cnt_w-1:0]   cnt_q;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(p_depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_comb begin
    full     = (cnt_q == cnt_w'(p_depth));
    empty    = (cnt_q == '0);
    count    = cnt_q;
    pop_data = mem[head_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= next_ptr(tail_q);
      if (pop)  head_q <= next_ptr(head_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + cnt_w'(1);
        2'b01:   cnt_q <= cnt_q - cnt_w'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_data;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one multi-cycle multiplier; responses are steered back by in-order tags.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned p_width        = 4,
  parameter int unsigned p_nreqs        = 2,
  parameter int unsigned p_max_inflight = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_nreqs-1:0]                  in_req_val,
  output logic [p_nreqs-1:0]                  in_req_rdy,
  input  logic [p_nreqs-1:0][2*p_width-1:0]   in_req_msg,
  output logic [p_nreqs-1:0]                  out_resp_val,
  input  logic [p_nreqs-1:0]                  out_resp_rdy,
  output logic [p_nreqs-1:0][2*p_width-1:0]   out_resp_msg,
  output logic                                mul_req_val,
  input  logic                                mul_req_rdy,
  output logic [2*p_width-1:0]                mul_req_msg,
  input  logic                                mul_resp_val,
  output logic                                mul_resp_rdy,
  input  logic [2*p_width-1:0]                mul_resp_msg
);

  localparam int unsigned tag_w = tag_width(p_nreqs);
  localparam int unsigned msg_w = msg_bits(p_width);
  localparam int unsigned cnt_w = $clog2(p_max_inflight + 1);

  typedef logic [msg_w-1:0] msg_t;

  logic [tag_w-1:0]   prio_q, prio_d, grant_idx, cand, head_tag;
  logic [p_nreqs-1:0] grant;
  logic               grant_found, can_issue, req_fire, resp_fire;
  logic               full, empty;
  logic [cnt_w-1:0]   count;
  logic               unused_count;
  int unsigned        sum;

  assign unused_count = ^count;

  // Grant search is suppressed during reset so every handshake output reads 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    cand        = '0;
    if (!reset) begin
      for (int unsigned k = 0; k < p_nreqs; k++) begin
        sum = 32'(prio_q) + k;
        if (sum >= p_nreqs) sum = sum - p_nreqs;
        cand = tag_w'(sum);
        if (!grant_found && in_req_val[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    grant = '0;
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    can_issue   = mul_req_rdy && !full && !reset;
    in_req_rdy  = grant & {p_nreqs{can_issue}};
    mul_req_val = can_issue && grant_found;
    mul_req_msg = grant_found ? msg_t'(in_req_msg[grant_idx]) : '0;
    req_fire    = mul_req_val && mul_req_rdy;
    prio_d      = prio_q;
    if (req_fire) begin
      prio_d = (grant_idx == tag_w'(p_nreqs - 1)) ? '0 : grant_idx + tag_w'(1);
    end
  end

  always_comb begin
    out_resp_val = '0;
    if (mul_resp_val && !empty) out_resp_val[head_tag] = 1'b1;
    mul_resp_rdy = !empty && out_resp_rdy[head_tag];
    resp_fire    = mul_resp_val && mul_resp_rdy;
    for (int unsigned i = 0; i < p_nreqs; i++) out_resp_msg[i] = mul_resp_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end

  mul_arb_tag_fifo #(
    .p_width (tag_w),
    .p_depth (p_max_inflight)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (grant_idx),
    .pop       (resp_fire),
    .pop_data  (head_tag),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter with a behavioural 3-cycle pipelined multiplier and a response scoreboard.
module tb_mul_arbiter;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      in_req_val, in_req_rdy, out_resp_val, out_resp_rdy;
  logic [1:0][7:0] in_req_msg, out_resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [7:0]      mul_req_msg, mul_resp_msg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic lane; logic [7:0] prod; } sb_t;
  sb_t  sb[$];
  logic grant_log[$];
  logic resp_log[$];
  logic m_prio;

  always #5 clk = ~clk;

  mul_arbiter #(
    .p_width        (4),
    .p_nreqs        (2),
    .p_max_inflight (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_req_val   (in_req_val),
    .in_req_rdy   (in_req_rdy),
    .in_req_msg   (in_req_msg),
    .out_resp_val (out_resp_val),
    .out_resp_rdy (out_resp_rdy),
    .out_resp_msg (out_resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg)
  );

  // Multiplier model: up to 4 in flight, each result valid 3 cycles after acceptance, in order.
  logic [7:0]  mq_prod [4];
  int unsigned mq_rdy  [4];
  logic [1:0]  mhead, mtail;
  logic [2:0]  mcnt;
  int unsigned cyc;

  assign mul_req_rdy  = (mcnt < 3'd4);
  assign mul_resp_val = (mcnt != 3'd0) && (cyc >= mq_rdy[mhead]);
  assign mul_resp_msg = mq_prod[mhead];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mhead <= '0;
      mtail <= '0;
      mcnt  <= '0;
      cyc   <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mul_req_val && mul_req_rdy) begin
        mq_prod[mtail] <= {4'b0, mul_req_msg[7:4]} * {4'b0, mul_req_msg[3:0]};
        mq_rdy[mtail]  <= cyc + 3;
        mtail          <= mtail + 2'd1;
      end
      if (mul_resp_val && mul_resp_rdy) mhead <= mhead + 2'd1;
      case ({mul_req_val && mul_req_rdy, mul_resp_val && mul_resp_rdy})
        2'b10:   mcnt <= mcnt + 3'd1;
        2'b01:   mcnt <= mcnt - 3'd1;
        default: mcnt <= mcnt;
      endcase
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [1:0] onehot(input logic l);
    return l ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] mul8(input logic [7:0] m);
    return {4'b0, m[7:4]} * {4'b0, m[3:0]};
  endfunction

  // Scoreboard monitor: models round-robin, 2-deep tag tracking and in-order steering.
  initial begin
    int   sz;
    logic g, h, can;
    m_prio = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        m_prio = 1'b0;
      end else begin
        sz = sb.size();
        if (sz == 0) begin
          chk("resp_when_empty", {29'b0, mul_resp_val, mul_resp_rdy, |out_resp_val}, 0);
        end else begin
          h = sb[0].lane;
          chk("resp_route", out_resp_val, mul_resp_val ? onehot(h) : 2'b00);
          chk("resp_rdy", mul_resp_rdy, out_resp_rdy[h]);
          if (mul_resp_val && mul_resp_rdy) begin
            chk("resp_data", out_resp_msg[h], sb[0].prod);
            resp_log.push_back(h);
            void'(sb.pop_front());
          end
        end
        if (in_req_val != 2'b00) begin
          g   = in_req_val[m_prio] ? m_prio : ~m_prio;
          can = mul_req_rdy && (sz < 2);
          chk("req_rdy", in_req_rdy, can ? onehot(g) : 2'b00);
          chk("req_val", mul_req_val, can);
          if (can) begin
            chk("req_msg", mul_req_msg, in_req_msg[g]);
            sb.push_back('{lane: g, prod: mul8(in_req_msg[g])});
            grant_log.push_back(g);
            m_prio = ~g;
          end
        end else begin
          chk("req_idle", {in_req_rdy, mul_req_val}, 0);
        end
      end
    end
  end

  task automatic send(input logic lane, input logic [7:0] m);
    bit ok = 0;
    @(posedge clk); #1;
    in_req_msg[lane] = m;
    in_req_val       = onehot(lane);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_req_rdy[lane]) begin ok = 1; break; end
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    in_req_val = 2'b00;
  endtask

  task automatic wait_resp(input logic lane, input logic [7:0] exp);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_resp_val[lane]) begin ok = 1; break; end
    end
    chk("resp_seen", ok, 1);
    if (ok) begin
      chk("resp_msg", out_resp_msg[lane], exp);
      chk("resp_lane_only", out_resp_val, onehot(lane));
      @(negedge clk);
      chk("resp_single_pulse", out_resp_val, 2'b00);
    end
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && mcnt == 3'd0) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  typedef struct { logic lane; logic [7:0] msg; logic [7:0] prod; } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{lane: 1'b1, msg: 8'h35, prod: 8'h0F};
    vecs[1] = '{lane: 1'b0, msg: 8'h77, prod: 8'h31};
    vecs[2] = '{lane: 1'b1, msg: 8'hFF, prod: 8'hE1};
    vecs[3] = '{lane: 1'b0, msg: 8'h00, prod: 8'h00};
    vecs[4] = '{lane: 1'b1, msg: 8'h9A, prod: 8'h5A};
    vecs[5] = '{lane: 1'b0, msg: 8'hF1, prod: 8'h0F};

    // Reset held with both requesters valid: every output stays 0.
    in_req_val   = 2'b11;
    in_req_msg   = {8'h45, 8'h23};
    out_resp_rdy = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_req_rdy", in_req_rdy, 2'b00);
      chk("rst_mul_req_val", mul_req_val, 0);
      chk("rst_mul_req_msg", mul_req_msg, 8'h00);
      chk("rst_out_resp_val", out_resp_val, 2'b00);
      chk("rst_mul_resp_rdy", mul_resp_rdy, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_grant", in_req_rdy, 2'b01);

    // Continuous contention: grants alternate.
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    in_req_val = 2'b00;
    drain("drain_rr");
    chk("grant_log_len", (grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      chk("grant_0", grant_log[0], 0);
      chk("grant_1", grant_log[1], 1);
      chk("grant_2", grant_log[2], 0);
      chk("grant_3", grant_log[3], 1);
    end

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].lane, vecs[i].msg);
      wait_resp(vecs[i].lane, vecs[i].prod);
    end
    drain("drain_vec");

    // Full FIFO blocks a third request; acceptance comes the cycle after the pop.
    out_resp_rdy = 2'b00;
    send(1'b0, 8'h23);
    send(1'b1, 8'h45);
    @(posedge clk); #1;
    in_req_msg[0] = 8'h67;
    in_req_val    = 2'b01;
    repeat (6) begin
      @(negedge clk);
      chk("full_blocks", in_req_rdy, 2'b00);
    end
    @(posedge clk); #1;
    out_resp_rdy = 2'b11;
    @(negedge clk);
    chk("pop_now", mul_resp_rdy, 1);
    chk("no_bypass", in_req_rdy, 2'b00);
    @(negedge clk);
    chk("accept_after_pop", in_req_rdy, 2'b01);
    @(posedge clk); #1;
    in_req_val = 2'b00;
    drain("drain_full");

    // Head-of-line blocking: lane 1 waits behind stalled lane 0.
    resp_log.delete();
    out_resp_rdy = 2'b10;
    send(1'b0, 8'h23);
    send(1'b1, 8'h45);
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mul_resp_val) begin ok = 1; break; end
      end
      chk("hol_resp_arrives", ok, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("hol_mul_resp_rdy", mul_resp_rdy, 0);
      chk("hol_out_resp_val", out_resp_val, 2'b01);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_resp_rdy = 2'b11;
    drain("drain_hol");
    chk("hol_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      chk("hol_order_0", resp_log[0], 0);
      chk("hol_order_1", resp_log[1], 1);
    end

    // Reset with two multiplies in flight.
    out_resp_rdy = 2'b00;
    send(1'b0, 8'h23);
    send(1'b1, 8'h45);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_count", dut.count, 0);
    chk("rst_mid_out_resp_val", out_resp_val, 2'b00);
    chk("rst_mid_mul_resp_rdy", mul_resp_rdy, 0);
    repeat (2) @(posedge clk);
    #1;
    out_resp_rdy = 2'b11;
    reset        = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_resp", out_resp_val, 2'b00);
    end
    send(1'b1, 8'h56);
    wait_resp(1'b1, 8'h1E);
    drain("drain_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
